// File: rtl/eeg_crypto_arbiter.sv
// rtl/eeg_crypto_arbiter.sv - round-robin packet arbiter feeding a single nonce-sequenced encryptor
module eeg_crypto_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 128,
    parameter int CTR_WIDTH   = 32,
    parameter int TAG_TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [95:0]                     nonce_seed,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              in_valid,
    input  logic [NUM_REQ-1:0]              in_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_REQ-1:0]              in_ready,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            enc_start,
    output logic [95:0]                     enc_nonce,
    output logic [DATA_WIDTH-1:0]           enc_data,
    output logic                            enc_valid,
    output logic                            enc_last,
    input  logic                            enc_ready,
    input  logic                            enc_tag_valid,
    output logic                            pkt_done,
    output logic [$clog2(NUM_REQ)-1:0]      pkt_owner,
    output logic                            busy,
    output logic                            fault,
    output logic [1:0]                      fault_code
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int TW    = $clog2(TAG_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_STREAM   = 3'd2;
    localparam logic [2:0] S_WAIT_TAG = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    logic [2:0]            state;
    logic [OWN_W-1:0]      owner;
    logic [OWN_W-1:0]      last_owner;
    logic [CTR_WIDTH-1:0]  pkt_ctr;
    logic [TW-1:0]         wait_cnt;
    logic [OWN_W-1:0]      rr_pick;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  own_valid;
    logic                  own_last;
    logic                  in_stream;
    logic                  fire;
    logic                  unused_seed_bits;

    // The low seed bits are replaced by the packet counter.
    assign unused_seed_bits = ^nonce_seed[CTR_WIDTH-1:0];

    function automatic logic [OWN_W-1:0] wrap_idx(input int v);
        return OWN_W'(v % NUM_REQ);
    endfunction

    // Walk downward so the nearest requester after last_owner is written last and wins.
    always_comb begin
        rr_pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[wrap_idx(int'(last_owner) + k)]) begin
                rr_pick = wrap_idx(int'(last_owner) + k);
            end
        end
    end

    always_comb begin
        own_data  = '0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                own_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                own_valid = in_valid[i];
                own_last  = in_last[i];
            end
        end
    end

    assign in_stream = (state == S_STREAM);
    assign enc_data  = in_stream ? own_data : '0;
    assign enc_valid = in_stream & own_valid;
    assign enc_last  = in_stream & own_last;
    assign in_ready  = in_stream ? (grant & {NUM_REQ{enc_ready}}) : '0;
    assign fire      = enc_valid & enc_ready;
    assign enc_start = (state == S_START);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_owner <= OWN_W'(NUM_REQ - 1);
            pkt_ctr    <= '0;
            wait_cnt   <= '0;
            grant      <= '0;
            enc_nonce  <= '0;
            pkt_done   <= 1'b0;
            pkt_owner  <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The done cycle is skipped so a req arriving with pkt_done sees updated last_owner.
                    if (!pkt_done && (|req)) begin
                        if (&pkt_ctr) begin
                            state      <= S_FAULT;
                            fault      <= 1'b1;
                            fault_code <= 2'b01;
                        end else begin
                            state     <= S_START;
                            owner     <= rr_pick;
                            grant     <= NUM_REQ'(1) << rr_pick;
                            enc_nonce <= {nonce_seed[95:CTR_WIDTH], pkt_ctr};
                        end
                    end
                end
                S_START: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (fire && enc_last) begin
                        state    <= S_WAIT_TAG;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT_TAG: begin
                    if (enc_tag_valid) begin
                        state      <= S_IDLE;
                        grant      <= '0;
                        pkt_done   <= 1'b1;
                        pkt_owner  <= owner;
                        last_owner <= owner;
                        pkt_ctr    <= pkt_ctr + 1'b1;
                    end else if (wait_cnt == TW'(TAG_TIMEOUT - 1)) begin
                        state      <= S_FAULT;
                        grant      <= '0;
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeg_crypto_arbiter.sv
// tb/tb_eeg_crypto_arbiter.sv - scoreboard bench for eeg_crypto_arbiter
module tb_eeg_crypto_arbiter;

    localparam int NR = 4;
    localparam int DW = 128;
    localparam logic [63:0] SEED_HI = 64'hA5A5A5A5_5A5A5A5A;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [95:0]       nonce_seed;
    logic [NR-1:0]     req, in_valid, in_last;
    logic [NR*DW-1:0]  in_data;
    logic              enc_ready, enc_tag_valid;

    logic [NR-1:0]     in_ready, grant;
    logic              enc_start, enc_valid, enc_last, pkt_done, busy, fault;
    logic [95:0]       enc_nonce;
    logic [DW-1:0]     enc_data;
    logic [1:0]        pkt_owner, fault_code;

    logic [NR-1:0]     b_in_ready, b_grant;
    logic              b_enc_start, b_enc_valid, b_enc_last, b_pkt_done, b_busy, b_fault;
    logic [95:0]       b_enc_nonce;
    logic [DW-1:0]     b_enc_data;
    logic [1:0]        b_pkt_owner, b_fault_code;

    always #5 clk = ~clk;

    eeg_crypto_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CTR_WIDTH(32), .TAG_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .nonce_seed(nonce_seed), .req(req), .in_valid(in_valid),
        .in_last(in_last), .in_data(in_data), .in_ready(in_ready), .grant(grant),
        .enc_start(enc_start), .enc_nonce(enc_nonce), .enc_data(enc_data), .enc_valid(enc_valid),
        .enc_last(enc_last), .enc_ready(enc_ready), .enc_tag_valid(enc_tag_valid),
        .pkt_done(pkt_done), .pkt_owner(pkt_owner), .busy(busy), .fault(fault), .fault_code(fault_code)
    );

    eeg_crypto_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CTR_WIDTH(2), .TAG_TIMEOUT(16)) dut_small (
        .clk(clk), .rst_n(rst_n), .nonce_seed(nonce_seed), .req(req), .in_valid(in_valid),
        .in_last(in_last), .in_data(in_data), .in_ready(b_in_ready), .grant(b_grant),
        .enc_start(b_enc_start), .enc_nonce(b_enc_nonce), .enc_data(b_enc_data), .enc_valid(b_enc_valid),
        .enc_last(b_enc_last), .enc_ready(enc_ready), .enc_tag_valid(enc_tag_valid),
        .pkt_done(b_pkt_done), .pkt_owner(b_pkt_owner), .busy(b_busy), .fault(b_fault),
        .fault_code(b_fault_code)
    );

    typedef struct packed {
        logic [95:0]   nonce;
        logic [NR-1:0] grant;
    } start_t;

    start_t       start_q[$];
    logic [128:0] xfer_q[$];
    logic [1:0]   done_q[$];
    start_t       mon_s;
    logic [128:0] mon_x;
    logic [1:0]   mon_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          b_starts = 0;
    int          pkt_idx = 0;
    logic [31:0] exp_ctr = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (enc_start) begin
                if (start_q.size() == 0) chk("unexpected_enc_start", enc_start, 0);
                else begin
                    mon_s = start_q.pop_front();
                    chk("start_nonce", enc_nonce, mon_s.nonce);
                    chk("start_grant", grant, mon_s.grant);
                end
            end
            if (enc_valid && enc_ready) begin
                if (xfer_q.size() == 0) chk("unexpected_transfer", enc_valid, 0);
                else begin
                    mon_x = xfer_q.pop_front();
                    chk("xfer_data", enc_data, mon_x[127:0]);
                    chk("xfer_last", enc_last, mon_x[128]);
                end
            end
            if (pkt_done) begin
                if (done_q.size() == 0) chk("unexpected_pkt_done", pkt_done, 0);
                else begin
                    mon_o = done_q.pop_front();
                    chk("pkt_owner", pkt_owner, mon_o);
                end
            end
            if (busy) chk("nonowner_in_ready", in_ready & ~grant, 0);
            if (b_enc_start) b_starts++;
        end
    end

    task automatic clear_inputs();
        req = '0; in_valid = '0; in_last = '0; in_data = '0;
        enc_ready = 1'b0; enc_tag_valid = 1'b0;
    endtask

    task automatic clear_model();
        start_q.delete(); xfer_q.delete(); done_q.delete();
        exp_ctr = 0; b_starts = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_drained(input string name);
        chk(name, start_q.size() + xfer_q.size() + done_q.size(), 0);
    endtask

    task automatic start_packet(input int o);
        start_t s;
        bit got;
        s.nonce = {SEED_HI, exp_ctr};
        s.grant = NR'(1) << o;
        start_q.push_back(s);
        req[o] = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = grant[o];
        end
        if (!got) chk("grant_timeout", grant, s.grant);
    endtask

    task automatic send_blocks(input int o, input int nblk, input bit toggle, input bit drop_req, input int stop_after);
        logic [DW-1:0] blk;
        bit fired;
        int cyc;
        cyc = 0;
        for (int b = 0; b < stop_after; b++) begin
            blk = {8'(o), 24'(pkt_idx), 32'(b), 64'h0123_4567_89AB_CDEF};
            for (int i = 0; i < NR; i++) in_data[i*DW +: DW] = (i == o) ? blk : ~blk;
            in_valid = '1;
            in_last  = (b == nblk - 1) ? (NR'(1) << o) : ~(NR'(1) << o);
            xfer_q.push_back({(b == nblk - 1), blk});
            fired = 0;
            for (int t = 0; t < 20 && !fired; t++) begin
                enc_ready = toggle ? (cyc % 2 == 0) : 1'b1;
                cyc++;
                @(negedge clk);
                chk("grant_locked", grant, NR'(1) << o);
                fired = in_ready[o];
                @(posedge clk);
                #1;
            end
            if (!fired) chk("xfer_timeout", in_ready[o], 1);
            if (drop_req && b == 0) req[o] = 1'b0;
        end
        in_valid = '0;
        in_last  = '0;
        pkt_idx++;
    endtask

    task automatic finish_tag(input int o, input logic [NR-1:0] clr);
        bit got;
        req = req & ~clr;
        repeat (2) @(posedge clk);
        #1;
        done_q.push_back(2'(o));
        enc_tag_valid = 1'b1;
        @(posedge clk);
        #1 enc_tag_valid = 1'b0;
        got = 0;
        for (int t = 0; t < 5 && !got; t++) begin
            @(negedge clk);
            got = pkt_done;
        end
        if (!got) chk("pkt_done_timeout", pkt_done, 1);
        exp_ctr++;
    endtask

    int fault_at;
    int fair_own[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nonce_seed = {SEED_HI, 32'hDEAD_BEEF};
        clear_inputs();
        #1;
        chk("reset_grant", grant, 0);
        chk("reset_flags", {enc_start, enc_valid, enc_last, pkt_done, busy, fault}, 0);
        chk("reset_nonce", enc_nonce, 0);
        do_reset();

        // single packet from requester 2, tag pulses in IDLE must be ignored
        enc_tag_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 enc_tag_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        start_packet(2);
        send_blocks(2, 3, 0, 0, 3);
        finish_tag(2, 4'b0000);
        start_packet(2);
        send_blocks(2, 1, 0, 0, 1);
        finish_tag(2, 4'b1111);
        repeat (4) @(negedge clk);
        check_drained("single_drained");

        // fairness with all requesters held
        do_reset();
        req = '1;
        for (int p = 0; p < 8; p++) begin
            start_packet(fair_own[p]);
            send_blocks(fair_own[p], 2, 0, 0, 2);
            finish_tag(fair_own[p], (p == 7) ? 4'b1111 : 4'b0000);
        end
        repeat (4) @(negedge clk);
        check_drained("fair_drained");

        // backpressure and packet lock
        do_reset();
        req = 4'b1001;
        start_packet(0);
        send_blocks(0, 4, 1, 1, 4);
        finish_tag(0, 4'b1111);
        repeat (4) @(negedge clk);
        check_drained("lock_drained");

        // tag timeout
        do_reset();
        start_packet(1);
        send_blocks(1, 2, 0, 0, 2);
        fault_at = -1;
        for (int t = 1; t <= 24 && fault_at < 0; t++) begin
            @(posedge clk);
            #1;
            if (fault) fault_at = t;
        end
        chk("timeout_cycles", fault_at, 16);
        chk("timeout_code", fault_code, 2'b10);
        req = '1; in_valid = '1; enc_ready = 1'b1; enc_tag_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("fault_grant", grant, 0);
        chk("fault_outputs", {enc_valid, enc_start, in_ready, busy, fault}, 7'b0000011);
        check_drained("timeout_drained");

        // nonce exhaustion on the 2-bit counter instance
        do_reset();
        for (int p = 0; p < 3; p++) begin
            start_packet(0);
            send_blocks(0, 1, 0, 0, 1);
            finish_tag(0, 4'b1111);
        end
        start_packet(0);
        repeat (3) @(negedge clk);
        chk("exhaust_fault", b_fault, 1);
        chk("exhaust_code", b_fault_code, 2'b01);
        chk("exhaust_grant", b_grant, 0);
        chk("exhaust_starts", b_starts, 3);

        // reset mid-stream abandons the packet
        do_reset();
        start_packet(2);
        send_blocks(2, 3, 0, 0, 1);
        in_valid = '1;
        req = '1;
        rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_nonce", enc_nonce, 0);
        chk("rst_flags", {enc_start, enc_valid, enc_last, pkt_done, busy, fault}, 0);
        chk("rst_owner_code", {pkt_owner, fault_code}, 0);
        chk("rst_in_ready", in_ready, 0);
        clear_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_packet(0);
        send_blocks(0, 2, 0, 0, 2);
        finish_tag(0, 4'b1111);
        repeat (4) @(negedge clk);
        check_drained("rst_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
